// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: producer/consumer handshake bundle for alu_result_fifo.
// slave modport is the FIFO side, master modport is the environment side.
interface alu_result_fifo_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_op;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_op;
    logic       out_ready;

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_op
    );

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_op
    );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: DEPTH-entry FIFO buffering ALU result bytes, with a sticky
// overflow flag and a saturating count of writes dropped while full.
// Optional macro ALU_RESULT_FIFO_TAG_EN stores the 3-bit opcode per entry and
// presents it on out_op; without it out_op is tied to 0.
// The head entry is held in a register loaded from the storage array (with a
// bypass for the slot being written), so outputs never fall through.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_result_fifo_if.slave    bus,
    output logic [4:0]          count,
    output logic                overflow,
    output logic [7:0]          drop_cnt,
    input  logic                clr_flags
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             push, pop, drop, full, empty, head_fwd;

    logic [7:0]       data_mem [DEPTH];
    logic [7:0]       head_data_q;

    // Handshake decode and next-state for pointers, occupancy and flags
    always_comb begin
        full       = (count_q == 5'(DEPTH));
        empty      = (count_q == 5'd0);
        push       = bus.in_valid & ~full;
        pop        = ~empty & bus.out_ready;
        drop       = bus.in_valid & full;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + 5'(push) - 5'(pop);
        // The head register must capture the incoming byte when the next
        // head slot is the one being written this very cycle.
        head_fwd   = push && (wr_ptr_q == rd_ptr_d);
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            // A drop coinciding with a clear restarts the count at one.
            overflow_d = 1'b1;
            if (clr_flags)
                drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF)
                drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Control state register; reset overrides any push, pop or clear
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Data storage with registered head read; contents are never cleared
    // because the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            data_mem[wr_ptr_q] <= bus.in_data;
        head_data_q <= head_fwd ? bus.in_data : data_mem[rd_ptr_d];
    end

`ifdef ALU_RESULT_FIFO_TAG_EN
    logic [2:0] tag_mem [DEPTH];
    logic [2:0] head_op_q;

    // Opcode tag storage mirroring the data path
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr_q] <= bus.in_op;
        head_op_q <= head_fwd ? bus.in_op : tag_mem[rd_ptr_d];
    end

    assign bus.out_op = empty ? 3'd0 : head_op_q;
`else
    logic unused_in_op;
    assign unused_in_op = ^bus.in_op;
    assign bus.out_op   = 3'd0;
`endif

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? 8'd0 : head_data_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, number of entries; SHALL be a power of two in the range 2..16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  ALU result present on in_data this cycle.
REQ-005 Port: in_data  input  8  ALU result byte.
REQ-006 Port: in_op  input  3  ALU opcode that produced in_data.
REQ-007 Port: in_ready  output  1  FIFO can accept a write this cycle.
REQ-008 Port: out_valid  output  1  head entry present on out_data/out_op.
REQ-009 Port: out_data  output  8  head entry data.
REQ-010 Port: out_op  output  3  head entry opcode tag.
REQ-011 Port: out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 Port: count  output  5  current occupancy, 0..DEPTH.
REQ-013 Port: overflow  output  1  sticky flag: a write was attempted while full.
REQ-014 Port: drop_cnt  output  8  number of dropped writes, saturating.
REQ-015 Port: clr_flags  input  1  clears overflow and drop_cnt.

Function
REQ-016 Push SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH), combinational from registered state only, never from in_valid or out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_data/out_op SHALL show the oldest entry, with no fall-through, so data pushed into an empty FIFO appears one cycle after the push.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged, and the new entry SHALL be written behind the popped head.
REQ-020 When full, in_valid with out_ready in the same cycle SHALL pop only; the write SHALL be dropped.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 out_data/out_op SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 in_valid=1 while in_ready=0 SHALL set overflow=1 and increment drop_cnt, saturating at 255.
REQ-024 clr_flags=1 SHALL clear overflow and drop_cnt next edge; a simultaneous drop SHALL win, giving overflow=1 and drop_cnt=1.
REQ-025 When empty, out_data and out_op SHALL be 0.

Reset
REQ-026 When reset=1 at a clock edge, pointers, count, overflow and drop_cnt SHALL clear to 0; afterwards out_valid=0, out_data=0, out_op=0, in_ready=1.
REQ-027 Reset SHALL take priority over push, pop and clr_flags; an in-flight push in the reset cycle SHALL be discarded.
REQ-028 Storage array contents need not be cleared; outputs SHALL be masked per REQ-025.

Configuration
REQ-029 Macro ALU_RESULT_FIFO_TAG_EN: when defined, in_op SHALL be stored per entry and presented on out_op.
REQ-030 When ALU_RESULT_FIFO_TAG_EN is undefined, no tag storage SHALL be built, in_op SHALL be ignored, and out_op SHALL be constant 0; all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, then push 0x12/op1, 0x34/op2 with out_ready=0 -> count=2, out_data=0x12, out_op=1 (TAG_EN), in_ready=1.
REQ-032 DEPTH=4: push 0xA0..0xA3, then in_valid with 0xFF -> in_ready=0, overflow=1, drop_cnt=1, and pops return A0,A1,A2,A3 in order.
REQ-033 Full FIFO, in_valid=1 and out_ready=1 for one cycle -> head A0 popped, 0xFF not stored, count=3, drop_cnt increments.
REQ-034 count=2, push and pop in the same cycle for 10 consecutive cycles -> count stays 2, pointers wrap, output sequence matches input order.
REQ-035 Hold in_valid=1 while full for 300 cycles -> drop_cnt=255; clr_flags=1 with in_valid=0 -> overflow=0, drop_cnt=0.
REQ-036 count=3, assert reset with in_valid=1 -> next cycle count=0, out_valid=0, out_data=0, overflow=0; without TAG_EN, out_op stays 0 throughout.
